i2s_tdm_rx: RTL and testbench

I2S_TDM_RX -- requirements
Module: i2s_tdm_rx

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_tdm_rx.sv | 151 +++++++++++++++
 tb/tb_i2s_tdm_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2s_pkg
// Brief  : Shared enums for the I2S/TDM serial audio receiver.
// Rev    : 1.0  initial release
// ============================================================================
package i2s_pkg;

    typedef enum logic [0:0] {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/i2s_tdm_rx.sv
`default_nettype none
// ============================================================================
// Module : i2s_tdm_rx
// Brief  : I2S / left-justified / TDM deserialiser with frame-length checking.
// Rev    : 1.0  initial release
// ============================================================================
module i2s_tdm_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 2,
    parameter int SLOT  = WIDTH
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   ws,
    input  logic                   sdata,
    input  logic                   fmt,
    output logic [NCH*WIDTH-1:0]   samples,
    output logic                   valid,
    output logic                   locked,
    output logic                   frame_err
);

    localparam int c_FRAME = NCH * SLOT;
    localparam int c_BCW   = $clog2(SLOT);
    localparam int c_SCW   = $clog2(NCH);
    localparam int c_ECW   = $clog2(c_FRAME + 2);

    localparam logic [c_BCW-1:0] c_BIT_LAST  = c_BCW'(SLOT - 1);
    localparam logic [c_BCW-1:0] c_WID_LAST  = c_BCW'(WIDTH - 1);
    localparam logic [c_SCW-1:0] c_SLOT_LAST = c_SCW'(NCH - 1);
    localparam logic [c_ECW-1:0] c_EDGE_EXP  = c_ECW'(c_FRAME);
    localparam logic [c_ECW-1:0] c_EDGE_TO   = c_ECW'(c_FRAME + 1);

    rx_state_e                r_state;
    fmt_e                     r_fmt_q;
    logic                     r_ws_d;
    logic [c_BCW-1:0]         r_bit_cnt;
    logic [c_SCW-1:0]         r_slot_cnt;
    logic [c_ECW-1:0]         r_edge_cnt;
    logic                     r_data_act;
    logic [WIDTH-1:0]         r_slot [NCH];
    logic [NCH*WIDTH-1:0]     r_samples;
    logic                     r_valid;
    logic                     r_locked;
    logic                     r_frame_err;

    logic                     w_fall;
    logic                     w_on_time;
    logic                     w_at_exp;
    logic                     w_timeout;
    logic                     w_take;
    logic                     w_last;
    logic                     w_commit;
    logic [WIDTH-1:0]         w_shifted;

    assign w_fall    = ~ws & r_ws_d;
    assign w_at_exp  = (r_edge_cnt == c_EDGE_EXP);
    assign w_on_time = w_fall & w_at_exp;
    assign w_timeout = ~w_fall & (r_edge_cnt == c_EDGE_TO);
    assign w_take    = r_data_act & (r_bit_cnt <= c_WID_LAST);
    assign w_last    = w_take & (r_slot_cnt == c_SLOT_LAST) & (r_bit_cnt == c_WID_LAST);
    assign w_shifted = {r_slot[r_slot_cnt][WIDTH-2:0], sdata};

    // In I2S with SLOT == WIDTH the final bit lands on the expected frame edge,
    // so the frame only counts as complete if ws actually falls there.
    assign w_commit  = (r_state == RUN) & w_last &
                       (w_fall ? w_on_time : ~(w_at_exp & (r_fmt_q == FMT_I2S)));

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state     <= SYNC;
            r_fmt_q     <= FMT_I2S;
            r_ws_d      <= 1'b1;
            r_bit_cnt   <= '0;
            r_slot_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_data_act  <= 1'b0;
            r_samples   <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_frame_err <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                r_slot[n] <= '0;
            end
        end else begin
            r_ws_d      <= ws;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_state == RUN) begin
                if (w_take) begin
                    r_slot[r_slot_cnt] <= w_shifted;
                end
                if (w_commit) begin
                    for (int n = 0; n < NCH; n++) begin
                        r_samples[n*WIDTH +: WIDTH] <= (n == NCH - 1) ? w_shifted : r_slot[n];
                    end
                    r_valid <= 1'b1;
                end
                if (r_data_act) begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_slot_cnt == c_SLOT_LAST) begin
                            r_data_act <= 1'b0;
                        end else begin
                            r_slot_cnt <= r_slot_cnt + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                r_edge_cnt <= r_edge_cnt + 1'b1;
                if (w_fall && !w_on_time) begin
                    r_frame_err <= 1'b1;
                end
                if (w_timeout) begin
                    r_frame_err <= 1'b1;
                    r_state     <= SYNC;
                    r_locked    <= 1'b0;
                    r_data_act  <= 1'b0;
                end
            end

            // Frame start (initial lock, on-time edge or early resync) overrides
            // the counter updates above.
            if (w_fall) begin
                r_state    <= RUN;
                r_locked   <= 1'b1;
                r_fmt_q    <= fmt_e'(fmt);
                r_slot_cnt <= '0;
                r_edge_cnt <= c_ECW'(1);
                r_data_act <= 1'b1;
                if (fmt_e'(fmt) == FMT_LJ) begin
                    r_slot[0] <= {r_slot[0][WIDTH-2:0], sdata};
                    r_bit_cnt <= c_BCW'(1);
                end else begin
                    r_bit_cnt <= '0;
                end
            end
        end
    end

    assign samples   = r_samples;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_i2s_tdm_rx
// Brief  : Scoreboard bench for i2s_tdm_rx (2-ch I2S/LJ and 4-slot TDM).
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2s_tdm_rx;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic        rst;
    logic        ws_a, sd_a, fmt_a;
    logic [31:0] samples_a;
    logic        valid_a, locked_a, err_a;
    logic        ws_b, sd_b, fmt_b;
    logic [63:0] samples_b;
    logic        valid_b, locked_b, err_b;

    i2s_tdm_rx #(.WIDTH(16), .NCH(2), .SLOT(16)) dut_a (
        .sclk(sclk), .rst(rst), .ws(ws_a), .sdata(sd_a), .fmt(fmt_a),
        .samples(samples_a), .valid(valid_a), .locked(locked_a), .frame_err(err_a)
    );

    i2s_tdm_rx #(.WIDTH(16), .NCH(4), .SLOT(32)) dut_b (
        .sclk(sclk), .rst(rst), .ws(ws_b), .sdata(sd_b), .fmt(fmt_b),
        .samples(samples_b), .valid(valid_b), .locked(locked_b), .frame_err(err_b)
    );

    int total = 0;
    int bad   = 0;
    int err_seen_a = 0;
    int err_seen_b = 0;
    logic [31:0] exp_a[$];
    logic [63:0] exp_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected frame.
    always @(negedge sclk) begin
        if (valid_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL valid_a unexpected: samples %h expected no pulse", samples_a);
            end else begin
                check("samples_a", {32'h0, samples_a}, {32'h0, exp_a.pop_front()});
            end
        end
        if (valid_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL valid_b unexpected: samples %h expected no pulse", samples_b);
            end else begin
                check("samples_b", samples_b, exp_b.pop_front());
            end
        end
        if (err_a === 1'b1) err_seen_a++;
        if (err_b === 1'b1) err_seen_b++;
    end

    task automatic tx_a(input logic w, input logic d);
        @(negedge sclk);
        ws_a = w;
        sd_a = d;
    endtask

    // Emits edges p0..p1-1 of a 2x16 frame; ws low for slot 0, high for slot 1.
    task automatic frame_a(input logic lj_stream, input logic fmt_pin,
                           input logic [15:0] l, input logic [15:0] r,
                           input int p0, input int p1, input logic prev);
        for (int p = p0; p < p1; p++) begin
            int   d;
            logic b;
            d = lj_stream ? p : p - 1;
            if (d >= 0 && d < 16)       b = l[15-d];
            else if (d >= 16 && d < 32) b = r[31-d];
            else                        b = prev;
            @(negedge sclk);
            fmt_a = fmt_pin;
            ws_a  = (p >= 16);
            sd_a  = b;
        end
    endtask

    // 4x32-slot TDM frame in I2S timing; padding bits are random.
    task automatic frame_b(input logic [63:0] v);
        for (int p = 0; p < 128; p++) begin
            int   d;
            logic b;
            logic [15:0] s;
            d = p - 1;
            if (d < 0) begin
                b = 1'($urandom_range(1));
            end else begin
                s = v[(d/32)*16 +: 16];
                b = ((d % 32) < 16) ? s[15 - (d % 32)] : 1'($urandom_range(1));
            end
            @(negedge sclk);
            ws_b = (p >= 120);
            sd_b = b;
        end
    endtask

    task automatic do_reset(input bit chk);
        @(negedge sclk);
        rst = 1'b1; ws_a = 1'b1; sd_a = 1'b0; ws_b = 1'b1; sd_b = 1'b0;
        @(negedge sclk);
        if (chk) begin
            check("rst_samples", {32'h0, samples_a}, 64'h0);
            check("rst_valid",   {63'h0, valid_a},   64'h0);
            check("rst_locked",  {63'h0, locked_a},  64'h0);
            check("rst_ferr",    {63'h0, err_a},     64'h0);
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ws_a = 1'b1; sd_a = 1'b0; fmt_a = 1'b0;
        ws_b = 1'b1; sd_b = 1'b0; fmt_b = 1'b0;
        repeat (3) @(negedge sclk);

        // Reset state
        do_reset(1);

        // I2S 2-channel frame
        exp_a.push_back(32'hBEEF_DEAD);
        frame_a(0, 0, 16'hDEAD, 16'hBEEF, 0, 32, 1'b0);
        tx_a(1'b0, 1'b1);
        @(negedge sclk);
        check("locked_i2s", {63'h0, locked_a}, 64'h1);
        do_reset(0);
        check("drain_i2s", 64'(exp_a.size()), 64'h0);

        // Left-justified stream, correct fmt
        exp_a.push_back(32'hBEEF_DEAD);
        frame_a(1, 1, 16'hDEAD, 16'hBEEF, 0, 32, 1'b0);
        do_reset(0);
        check("drain_lj", 64'(exp_a.size()), 64'h0);

        // Left-justified stream decoded as I2S: one-bit misalignment
        exp_a.push_back(32'h7DDE_BD5B);
        frame_a(1, 0, 16'hDEAD, 16'hBEEF, 0, 32, 1'b0);
        tx_a(1'b0, 1'b0);
        do_reset(0);
        check("drain_lj_as_i2s", 64'(exp_a.size()), 64'h0);

        // Early frame edge 5 bits before the end of frame 2
        exp_a.push_back(32'h5678_1234);
        frame_a(0, 0, 16'h1234, 16'h5678, 0, 32, 1'b0);
        frame_a(0, 0, 16'hAAAA, 16'h5555, 0, 27, 1'b0);
        check("no_err_before_early", 64'(err_seen_a), 64'h0);
        exp_a.push_back(32'hEF01_ABCD);
        frame_a(0, 0, 16'hABCD, 16'hEF01, 0, 10, 1'b1);
        check("err_early", 64'(err_seen_a), 64'h1);
        check("samples_held", {32'h0, samples_a}, 64'h5678_1234);
        check("locked_after_resync", {63'h0, locked_a}, 64'h1);
        frame_a(0, 0, 16'hABCD, 16'hEF01, 10, 32, 1'b1);
        tx_a(1'b0, 1'b1);
        do_reset(0);
        check("drain_early", 64'(exp_a.size()), 64'h0);

        // ws stuck high after one frame -> timeout
        exp_a.push_back(32'hBEEF_DEAD);
        frame_a(0, 0, 16'hDEAD, 16'hBEEF, 0, 32, 1'b0);
        tx_a(1'b0, 1'b1);
        for (int p = 1; p <= 32; p++) tx_a(1'b1, 1'($urandom_range(1)));
        tx_a(1'b1, 1'b0);
        check("locked_before_timeout", {63'h0, locked_a}, 64'h1);
        check("ferr_before_timeout",   {63'h0, err_a},    64'h0);
        tx_a(1'b1, 1'b0);
        check("locked_after_timeout", {63'h0, locked_a}, 64'h0);
        check("ferr_pulse_timeout",   {63'h0, err_a},    64'h1);
        repeat (4) tx_a(1'b1, 1'b0);
        check("err_total_timeout", 64'(err_seen_a), 64'h2);
        do_reset(0);
        check("drain_timeout", 64'(exp_a.size()), 64'h0);

        // Reset in slot 1 bit 7, then a clean frame
        exp_a.push_back(32'h2222_1111);
        frame_a(0, 0, 16'h1111, 16'h2222, 0, 32, 1'b0);
        frame_a(0, 0, 16'h3333, 16'h4444, 0, 25, 1'b0);
        do_reset(1);
        exp_a.push_back(32'hF00D_CAFE);
        frame_a(0, 0, 16'hCAFE, 16'hF00D, 0, 32, 1'b0);
        tx_a(1'b0, 1'b1);
        do_reset(0);
        check("drain_midrst", 64'(exp_a.size()), 64'h0);
        check("err_total_a",  64'(err_seen_a), 64'h2);

        // TDM: 4 slots of 32 clocks, 16-bit samples
        exp_b.push_back(64'h4444_3333_2222_1111);
        exp_b.push_back(64'hF0F0_0F0F_5A5A_A5A5);
        frame_b(64'h4444_3333_2222_1111);
        check("locked_tdm", {63'h0, locked_b}, 64'h1);
        frame_b(64'hF0F0_0F0F_5A5A_A5A5);
        do_reset(0);
        check("drain_tdm", 64'(exp_b.size()), 64'h0);
        check("err_total_b", 64'(err_seen_b), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
